// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared encodings and constants for the RAM arbiter
// Purpose: FSM state encoding, owner encoding and global constants used by
//          ram_arbiter, ram_arb_pick and the bus interface.
// Ports:   none (package).
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  localparam logic        RST_ENABLE   = 1'b0;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  // Starve counter holds up to 15, wait counter up to RAM_LATENCY-1 = 6.
  localparam int STARVE_W = 4;
  localparam int WAIT_W   = 3;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - pipeline-side and RAM-side bus bundle of the arbiter
// Purpose: groups the I port, D port, RAM macro and status signals.
// Ports:   slave  - the arbiter's view (requests and ram_read_data in).
//          master - the environment's view (pipeline and RAM macro).
interface ram_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_write_en;
  logic [3:0]  d_write_sel;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        ram_en;
  logic        ram_write_en;
  logic [3:0]  ram_write_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;

  logic        busy;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_write_en, d_write_sel, d_addr, d_wdata,
    input  ram_read_data,
    output if_ready, if_rvalid, if_rdata,
    output d_ready, d_rvalid, d_rdata,
    output ram_en, ram_write_en, ram_write_sel, ram_addr, ram_write_data,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_write_en, d_write_sel, d_addr, d_wdata,
    output ram_read_data,
    input  if_ready, if_rvalid, if_rdata,
    input  d_ready, d_rvalid, d_rdata,
    input  ram_en, ram_write_en, ram_write_sel, ram_addr, ram_write_data,
    input  busy
  );

endinterface

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational winner select between I and D requests
// Purpose: D wins by default; I wins when alone or when D has starved it.
// Ports:   if_req_i, d_req_i  - pending requests
//          starve_cnt_i       - consecutive D grants seen while I waited
//          pick_i_o, pick_d_o - one-hot (or zero) winner
module ram_arb_pick
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                if_req_i,
  input  logic                d_req_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  output logic                pick_i_o,
  output logic                pick_d_o
);

  logic starved;

  assign starved  = if_req_i && (starve_cnt_i == STARVE_W'(STARVE_LIMIT));
  assign pick_i_o = if_req_i && (!d_req_i || starved);
  assign pick_d_o = d_req_i && !starved;

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter between fetch and load/store
// Purpose: grants one of I/D in IDLE, issues one RAM cycle, waits out the
//          RAM read latency and returns data/ack with a one-cycle rvalid.
// Ports:   clk - rising-edge clock
//          rst - asynchronous active-low reset
//          bus - ram_arbiter_if.slave (I port, D port, RAM macro, busy)
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int RAM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  arb_state_e          state_q;
  owner_e              owner_q;
  logic                store_q;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [WAIT_W-1:0]   wait_q;

  logic        ram_en_q, ram_we_q;
  logic [3:0]  ram_sel_q;
  logic [31:0] ram_addr_q, ram_wdata_q;
  logic        if_rvalid_q, d_rvalid_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  logic pick_i, pick_d, grant_i, grant_d, can_grant;

  ram_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .if_req_i     (bus.if_req),
    .d_req_i      (bus.d_req),
    .starve_cnt_i (starve_q),
    .pick_i_o     (pick_i),
    .pick_d_o     (pick_d)
  );

  // Readies are combinational so the requester sees the accept in the same
  // cycle; they are held low while reset is asserted.
  assign can_grant = (state_q == ARB_IDLE) && (rst != RST_ENABLE);
  assign grant_i   = can_grant && pick_i;
  assign grant_d   = can_grant && pick_d;

  always_comb begin
    starve_d = starve_q;
    if (grant_i) begin
      starve_d = '0;
    end else if (grant_d) begin
      if (!bus.if_req) begin
        starve_d = '0;
      end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_I;
      store_q     <= 1'b0;
      starve_q    <= '0;
      wait_q      <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_sel_q   <= 4'b0000;
      ram_addr_q  <= ZERO_WORD;
      ram_wdata_q <= ZERO_WORD;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= ZERO_WORD;
      d_rdata_q   <= ZERO_WORD;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      starve_q    <= starve_d;
      case (state_q)
        ARB_IDLE: begin
          if (grant_i) begin
            owner_q     <= OWNER_I;
            store_q     <= 1'b0;
            ram_en_q    <= CHIP_ENABLE;
            ram_we_q    <= 1'b0;
            ram_sel_q   <= 4'b0000;
            ram_addr_q  <= bus.if_addr;
            ram_wdata_q <= ZERO_WORD;
            state_q     <= ARB_ISSUE;
          end else if (grant_d) begin
            owner_q     <= OWNER_D;
            store_q     <= (bus.d_write_en == WRITE_ENABLE);
            ram_en_q    <= CHIP_ENABLE;
            ram_we_q    <= (bus.d_write_en == WRITE_ENABLE);
            ram_sel_q   <= (bus.d_write_en == WRITE_ENABLE) ? bus.d_write_sel : 4'b0000;
            ram_addr_q  <= bus.d_addr;
            ram_wdata_q <= (bus.d_write_en == WRITE_ENABLE) ? bus.d_wdata : ZERO_WORD;
            state_q     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          // ram_en was high for this one cycle; address and data stay put.
          ram_en_q  <= 1'b0;
          ram_we_q  <= 1'b0;
          ram_sel_q <= 4'b0000;
          wait_q    <= WAIT_W'(RAM_LATENCY - 1);
          state_q   <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (wait_q == '0) begin
            if (owner_q == OWNER_I) begin
              if_rdata_q  <= bus.ram_read_data;
              if_rvalid_q <= 1'b1;
            end else begin
              d_rdata_q  <= store_q ? ZERO_WORD : bus.ram_read_data;
              d_rvalid_q <= 1'b1;
            end
            state_q <= ARB_IDLE;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.if_ready       = grant_i;
  assign bus.d_ready        = grant_d;
  assign bus.if_rvalid      = if_rvalid_q;
  assign bus.if_rdata       = if_rdata_q;
  assign bus.d_rvalid       = d_rvalid_q;
  assign bus.d_rdata        = d_rdata_q;
  assign bus.ram_en         = ram_en_q;
  assign bus.ram_write_en   = ram_we_q;
  assign bus.ram_write_sel  = ram_sel_q;
  assign bus.ram_addr       = ram_addr_q;
  assign bus.ram_write_data = ram_wdata_q;
  assign bus.busy           = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;

  typedef struct packed {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
  } in_t;

  typedef struct packed {
    logic        if_ready;
    logic        d_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        busy;
  } out_t;

  typedef struct {
    in_t  i;
    out_t x;
  } vec_t;

  localparam logic [31:0] BAD = 32'hBADB_AD00;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ram_arbiter_if bus1 ();
  ram_arbiter_if bus3 ();

  ram_arbiter #(.RAM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  ram_arbiter #(.RAM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  function automatic logic [31:0] ram_lookup(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hDEAD_BEEF;
      32'h0000_0080: return 32'hCAFE_F00D;
      default:       return {~a[15:0], a[15:0]};
    endcase
  endfunction

  // RAM models: data appears RAM_LATENCY cycles after the ram_en cycle,
  // a poison word at every other time.
  logic [31:0] rd1_q = BAD;
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    rd1_q <= (bus1.ram_en && !bus1.ram_write_en) ? ram_lookup(bus1.ram_addr) : BAD;
    p3[0] <= (bus3.ram_en && !bus3.ram_write_en) ? ram_lookup(bus3.ram_addr) : BAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus1.ram_read_data = rd1_q;
  assign bus3.ram_read_data = p3[2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic apply1(input in_t v);
    rst              = v.rst;
    bus1.if_req      = v.if_req;
    bus1.if_addr     = v.if_addr;
    bus1.d_req       = v.d_req;
    bus1.d_write_en  = v.d_we;
    bus1.d_write_sel = v.d_sel;
    bus1.d_addr      = v.d_addr;
    bus1.d_wdata     = v.d_wdata;
  endtask

  function automatic out_t sample1();
    out_t o;
    o.if_ready  = bus1.if_ready;
    o.d_ready   = bus1.d_ready;
    o.if_rvalid = bus1.if_rvalid;
    o.if_rdata  = bus1.if_rdata;
    o.d_rvalid  = bus1.d_rvalid;
    o.d_rdata   = bus1.d_rdata;
    o.ram_en    = bus1.ram_en;
    o.ram_we    = bus1.ram_write_en;
    o.ram_sel   = bus1.ram_write_sel;
    o.ram_addr  = bus1.ram_addr;
    o.ram_wdata = bus1.ram_write_data;
    o.busy      = bus1.busy;
    return o;
  endfunction

  vec_t vecs[$];
  in_t  idle_in;
  out_t act;
  int   ngrant;
  int   gcyc [10];
  logic gis_i [10];

  initial begin
    idle_in = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.d_req = 1'b0; bus3.d_write_en = 1'b0;
    bus3.d_write_sel = '0; bus3.d_addr = '0; bus3.d_wdata = '0;

    // in:  rst, if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata
    // out: if_ready, d_ready, if_rvalid, if_rdata, d_rvalid, d_rdata,
    //      ram_en, ram_we, ram_sel, ram_addr, ram_wdata, busy
    vecs.push_back('{'{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0},
                     '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0}});
    vecs.push_back('{idle_in, '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0}});
    // I read of 0x100
    vecs.push_back('{'{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0},
                     '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0}});
    vecs.push_back('{idle_in, '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b1}});
    vecs.push_back('{idle_in, '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 1'b1}});
    vecs.push_back('{idle_in, '{1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0}});
    vecs.push_back('{idle_in, '{1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0}});
    // D store 0x40, sel 0011
    vecs.push_back('{'{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h40, 32'h12345678},
                     '{1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0}});
    vecs.push_back('{idle_in, '{1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h40, 32'h12345678, 1'b1}});
    vecs.push_back('{idle_in, '{1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h40, 32'h12345678, 1'b1}});
    // store ack; both request in the same cycle, D load wins
    vecs.push_back('{'{1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0},
                     '{1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h40, 32'h12345678, 1'b0}});
    vecs.push_back('{'{1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0},
                     '{1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0, 1'b1}});
    vecs.push_back('{'{1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0},
                     '{1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h80, 32'h0, 1'b1}});
    // I granted in the cycle D's rvalid pulses
    vecs.push_back('{'{1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0},
                     '{1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 4'h0, 32'h80, 32'h0, 1'b0}});
    vecs.push_back('{idle_in, '{1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 4'h0, 32'h104, 32'h0, 1'b1}});
    vecs.push_back('{idle_in, '{1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 4'h0, 32'h104, 32'h0, 1'b1}});
    vecs.push_back('{idle_in, '{1'b0, 1'b0, 1'b1, 32'hFEFB0104, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 4'h0, 32'h104, 32'h0, 1'b0}});
    // store with no byte lanes is still issued and acknowledged
    vecs.push_back('{'{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h44, 32'hA5A5A5A5},
                     '{1'b0, 1'b1, 1'b0, 32'hFEFB0104, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 4'h0, 32'h104, 32'h0, 1'b0}});
    vecs.push_back('{idle_in, '{1'b0, 1'b0, 1'b0, 32'hFEFB0104, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1, 4'h0, 32'h44, 32'hA5A5A5A5, 1'b1}});
    vecs.push_back('{idle_in, '{1'b0, 1'b0, 1'b0, 32'hFEFB0104, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 4'h0, 32'h44, 32'hA5A5A5A5, 1'b1}});
    vecs.push_back('{idle_in, '{1'b0, 1'b0, 1'b0, 32'hFEFB0104, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h44, 32'hA5A5A5A5, 1'b0}});
    vecs.push_back('{idle_in, '{1'b0, 1'b0, 1'b0, 32'hFEFB0104, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h44, 32'hA5A5A5A5, 1'b0}});

    apply1(vecs[0].i);
    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      apply1(vecs[n].i);
      #1;
      act = sample1();
      vectors++;
      if (act !== vecs[n].x) begin
        miscompares++;
        $display("FAIL vec%0d got %h want %h", n, act, vecs[n].x);
      end
    end

    // Both requests held: expect D,D,D,D,I,D,D,D,D,I, one grant every 3 cycles.
    @(negedge clk);
    bus1.if_req = 1'b1; bus1.if_addr = 32'h300;
    bus1.d_req = 1'b1; bus1.d_write_en = 1'b0; bus1.d_write_sel = '0; bus1.d_addr = 32'h200;
    ngrant = 0;
    for (int c = 0; c < 60 && ngrant < 10; c++) begin
      #1;
      if (bus1.if_ready && bus1.d_ready) check("both_ready", 64'd1, 64'd0);
      if (bus1.if_ready || bus1.d_ready) begin
        gcyc[ngrant]  = c;
        gis_i[ngrant] = bus1.if_ready;
        ngrant++;
      end
      @(negedge clk);
    end
    bus1.if_req = 1'b0; bus1.d_req = 1'b0;
    check("starve_ngrant", 64'(ngrant), 64'd10);
    for (int k = 0; k < ngrant; k++) begin
      check($sformatf("starve_order%0d", k), 64'(gis_i[k]), 64'((k == 4) || (k == 9)));
      if (k > 0) check($sformatf("starve_gap%0d", k), 64'(gcyc[k] - gcyc[k-1]), 64'd3);
    end
    repeat (6) @(negedge clk);

    // Reset in WAIT abandons the access.
    bus1.if_req = 1'b1; bus1.if_addr = 32'h100;
    #1 check("rst_seq_grant", 64'(bus1.if_ready), 64'd1);
    @(negedge clk); bus1.if_req = 1'b0;
    @(negedge clk);
    #1 check("rst_seq_in_wait", 64'(bus1.busy), 64'd1);
    rst = 1'b0;
    #1 check("rst_async_outs", {bus1.ram_en, bus1.busy, bus1.if_rvalid, bus1.d_rvalid, bus1.if_ready, bus1.if_rdata},
             64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 check($sformatf("rst_no_rvalid%0d", k), {bus1.if_rvalid, bus1.d_rvalid, bus1.busy}, 64'd0);
    end
    @(negedge clk);
    bus1.if_req = 1'b1; bus1.if_addr = 32'h100;
    #1 check("post_rst_grant", 64'(bus1.if_ready), 64'd1);
    @(negedge clk); bus1.if_req = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 check("post_rst_rdata", {bus1.if_rvalid, bus1.if_rdata}, {32'd1, 32'hDEADBEEF});

    // RAM_LATENCY = 3: D load from 0x80.
    @(negedge clk);
    bus3.d_req = 1'b1; bus3.d_write_en = 1'b0; bus3.d_addr = 32'h80;
    #1 check("lat3_grant", 64'(bus3.d_ready), 64'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus3.d_req = 1'b0;
      #1 check($sformatf("lat3_t%0d", k), {bus3.busy, bus3.ram_en, bus3.d_rvalid},
               {61'd0, (k <= 4), (k == 1), (k == 5)});
      if (k == 5) check("lat3_rdata", 64'(bus3.d_rdata), 64'hCAFEF00D);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port synchronous data/instruction RAM between two requesters: instruction fetch (I port, read-only) and load/store (D port, fed by the ID/EX load-store path: enable, write enable, byte select, write data).
- Sequences each access through an IDLE/ISSUE/WAIT FSM and accounts for a fixed RAM read latency.
- Returns read data or a write acknowledgement with a one-cycle valid pulse.
- Sits between the pipeline memory interfaces and the RAM macro.

Parameters:
- RAM_LATENCY, 1, cycles from the ram_en edge to valid ram_read_data; legal range 1..7.
- STARVE_LIMIT, 4, maximum consecutive D grants while if_req is pending before I is forced; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (RST_ENABLE = 1'b0).
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  32  fetch byte address.
- if_ready  out  1  grant/accept strobe for the I port.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  fetched word.
- d_req  in  1  load/store request; fields held until d_ready.
- d_write_en  in  1  1 = store, 0 = load.
- d_write_sel  in  4  byte lane enables for a store.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_ready  out  1  grant/accept strobe for the D port.
- d_rvalid  out  1  one-cycle pulse; load data valid or store acknowledged.
- d_rdata  out  32  load word; 0 for stores.
- ram_en  out  1  RAM chip enable.
- ram_write_en  out  1  RAM write enable.
- ram_write_sel  out  4  RAM byte enables.
- ram_addr  out  32  RAM address.
- ram_write_data  out  32  RAM write data.
- ram_read_data  in  32  RAM read data.
- busy  out  1  high in ISSUE or WAIT.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE; starve counter clears.
  - All outputs are 0 immediately: ram_* registers, *_rvalid, *_rdata, busy.
  - *_ready are forced 0.
  - Any in-flight access is abandoned. No rvalid is ever produced for it after reset is released.
- IDLE:
  - Exactly one of if_ready/d_ready is asserted, combinationally, in the same cycle T as the winning request.
  - Arbitration: D wins by default. I wins if only if_req is high, or if both are high and starve_cnt == STARVE_LIMIT.
  - At the T edge the winner's fields are latched into the ram_* registers, an owner bit is recorded, and state goes to ISSUE.
- starve_cnt:
  - Increments on every D grant while if_req = 1, saturating at STARVE_LIMIT.
  - Clears on every I grant, and on any D grant with if_req = 0.
- ISSUE (cycle T+1):
  - ram_en = 1 for exactly this cycle. ram_write_en = latched d_write_en (0 for the I owner).
  - Wait counter loads RAM_LATENCY-1; next state is WAIT.
- WAIT:
  - ram_en = 0; ram_write_en and ram_write_sel return to 0.
  - When the counter is 0: capture ram_read_data into the owner's rdata (0 if store), pulse the owner's rvalid in the next cycle, and return to IDLE.
  - Otherwise decrement the counter.
- Latency: grant at T → rvalid at T+2+RAM_LATENCY.
- Throughput: one access per RAM_LATENCY+2 cycles. A new grant may occur in the same cycle as the rvalid pulse.
- rdata holds its value until that port's next capture. The non-owner's rdata is untouched.
- Requests seen during ISSUE/WAIT are not acknowledged (ready = 0); the requester keeps holding.
- A store with d_write_sel = 0 is still issued (no-op write) and acknowledged.
- No alignment checks or sub-word extraction; addresses pass through unmodified.
- Simultaneous requests with starve_cnt below the limit: D is granted, I waits.

Decomposition:
- Shared define file arb_def.v: state encodings ARB_IDLE/ARB_ISSUE/ARB_WAIT (2 bits) and the owner encoding OWNER_I/OWNER_D.
- Reuse the existing global defines: RST_ENABLE, CHIP_ENABLE, WRITE_ENABLE, ZERO_WORD.
- One sub-module, ram_arb_pick: purely combinational winner select from if_req, d_req and starve_cnt.

Test Plan:
- I read, RAM_LATENCY = 1, if_addr = 0x00000100, RAM returns 0xDEADBEEF → if_ready at T; ram_en = 1 with ram_addr = 0x100 only at T+1; if_rvalid = 1 with if_rdata = 0xDEADBEEF only at T+3.
- D store: d_addr = 0x40, sel = 4'b0011, wdata = 0x12345678 → one cycle of ram_en = ram_write_en = 1 with those values; d_rvalid at T+3 with d_rdata = 0.
- if_req and d_req both high from idle → D granted first; I granted in the cycle D's rvalid pulses; if_rvalid 3 cycles later.
- Both held continuously, STARVE_LIMIT = 4 → grant order D, D, D, D, I, D…; starve_cnt back to 0 after the I grant.
- Reset asserted during WAIT → ram_en, busy and rvalid are 0 immediately; after release, no rvalid appears for the abandoned access and the next if_req is granted normally.
- RAM_LATENCY = 3, D load from 0x80, RAM returns 0xCAFEF00D → d_rvalid at T+5 with d_rdata = 0xCAFEF00D; busy high T+1..T+4.
